adc_conv_scheduler: RTL

- Clocked sequencer that shares one SAR ADC FSM (12/14-bit selectable) among NCH requesting channels.
- Arbitrates requests round-robin and drives the analog input mux select and resolution mode.
- Per grant, issues 2^OSR_LOG2 back-to-back st_conv pulses, accumulates the results and returns the averaged code with a channel tag.
- Sits between the digital control/readout logic and the asynchronous ADC FSM/comparator loop.

---
 rtl/adc_conv_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/adc_conv_scheduler.sv
// Round-robin scheduler sharing one SAR ADC among NCH channels.
// Each grant settles the mux, runs 2^OSR_LOG2 conversions and returns their truncated average.
module adc_conv_scheduler #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned CH_W        = 2,
   parameter int unsigned RES_W       = 14,
   parameter int unsigned OSR_LOG2    = 2,
   parameter int unsigned SETTLE_CYC  = 8,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    mode_14b,
   output logic [NCH-1:0]    ack,
   output logic [CH_W-1:0]   mux_sel,
   output logic              sel_14b,
   output logic              st_conv,
   input  logic              adc_done,
   input  logic [RES_W-1:0]  adc_result,
   output logic              out_valid,
   output logic [RES_W-1:0]  out_data,
   output logic [CH_W-1:0]   out_chan,
   output logic              out_err,
   output logic              busy
);
   localparam int unsigned ACC_W     = RES_W + OSR_LOG2;
   localparam int unsigned CNT_W     = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
   localparam int unsigned TMR_MAX   = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
   localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
   localparam int unsigned CONV_LAST = (1 << OSR_LOG2) - 1;

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_OUTPUT} state_t;

   state_t             state, state_nx;
   logic [CH_W-1:0]    chan, chan_nx, last_grant, last_nx;
   logic [ACC_W-1:0]   acc, acc_nx, sample;
   logic [CNT_W-1:0]   conv_cnt, cnt_nx;
   logic [TMR_W-1:0]   tmr, tmr_nx;
   logic               err, err_nx;
   logic               done_s1, done_s2, done_s3, done_evt;
   logic [CH_W-1:0]    rr_pick, rr_cand;
   logic               rr_found;
   logic [NCH-1:0]     ack_nx;
   logic [CH_W-1:0]    mux_sel_nx, out_chan_nx;
   logic               sel_14b_nx, st_conv_nx, out_valid_nx, out_err_nx, busy_nx;
   logic [RES_W-1:0]   out_data_nx;

   // adc_done is asynchronous: two-flop synchronizer plus rising-edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         done_s1 <= 1'b0;
         done_s2 <= 1'b0;
         done_s3 <= 1'b0;
      end else begin
         done_s1 <= adc_done;
         done_s2 <= done_s1;
         done_s3 <= done_s2;
      end
   end
   assign done_evt = done_s2 & ~done_s3;

   // First requesting channel after last_grant, wrapping around
   always_comb begin
      rr_pick  = '0;
      rr_found = 1'b0;
      rr_cand  = '0;
      for (int unsigned i = 1; i <= NCH; i++) begin
         rr_cand = CH_W'((32'(last_grant) + i) % NCH);
         if (!rr_found && req[rr_cand]) begin
            rr_found = 1'b1;
            rr_pick  = rr_cand;
         end
      end
   end

   // 12-bit mode ignores the two upper result bits
   assign sample = sel_14b ? ACC_W'(adc_result) : ACC_W'(adc_result[11:0]);

   always_comb begin
      state_nx     = state;
      chan_nx      = chan;
      last_nx      = last_grant;
      acc_nx       = acc;
      cnt_nx       = conv_cnt;
      tmr_nx       = tmr;
      err_nx       = err;
      mux_sel_nx   = mux_sel;
      sel_14b_nx   = sel_14b;
      st_conv_nx   = 1'b0;
      out_valid_nx = 1'b0;
      ack_nx       = '0;
      out_data_nx  = out_data;
      out_chan_nx  = out_chan;
      out_err_nx   = out_err;
      unique case (state)
         S_IDLE: begin
            if (rr_found) begin
               chan_nx    = rr_pick;
               mux_sel_nx = rr_pick;
               sel_14b_nx = mode_14b[rr_pick];
               acc_nx     = '0;
               cnt_nx     = '0;
               tmr_nx     = '0;
               err_nx     = 1'b0;
               state_nx   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
               tmr_nx   = '0;
               state_nx = S_START;
            end else begin
               tmr_nx = tmr + 1'b1;
            end
         end
         S_START: begin
            st_conv_nx = 1'b1;
            tmr_nx     = '0;
            state_nx   = S_WAIT;
         end
         S_WAIT: begin
            // a done edge in the same cycle as the timeout takes priority
            if (done_evt) begin
               acc_nx = acc + sample;
               if (conv_cnt == CNT_W'(CONV_LAST)) begin
                  state_nx = S_OUTPUT;
               end else begin
                  cnt_nx   = conv_cnt + 1'b1;
                  state_nx = S_START;
               end
            end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
               err_nx   = 1'b1;
               state_nx = S_OUTPUT;
            end else begin
               tmr_nx = tmr + 1'b1;
            end
         end
         S_OUTPUT: begin
            last_nx  = chan;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (state_nx == S_OUTPUT) begin
         out_valid_nx = 1'b1;
         out_chan_nx  = chan_nx;
         out_err_nx   = err_nx;
         out_data_nx  = err_nx ? '0 : RES_W'(acc_nx >> OSR_LOG2);
         ack_nx       = NCH'(1) << chan_nx;
      end
      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         chan       <= '0;
         last_grant <= CH_W'(NCH - 1);
         acc        <= '0;
         conv_cnt   <= '0;
         tmr        <= '0;
         err        <= 1'b0;
         mux_sel    <= '0;
         sel_14b    <= 1'b0;
         st_conv    <= 1'b0;
         out_valid  <= 1'b0;
         ack        <= '0;
         out_data   <= '0;
         out_chan   <= '0;
         out_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         chan       <= chan_nx;
         last_grant <= last_nx;
         acc        <= acc_nx;
         conv_cnt   <= cnt_nx;
         tmr        <= tmr_nx;
         err        <= err_nx;
         mux_sel    <= mux_sel_nx;
         sel_14b    <= sel_14b_nx;
         st_conv    <= st_conv_nx;
         out_valid  <= out_valid_nx;
         ack        <= ack_nx;
         out_data   <= out_data_nx;
         out_chan   <= out_chan_nx;
         out_err    <= out_err_nx;
         busy       <= busy_nx;
      end
   end
endmodule
